// File: rtl/if_stage_if.sv
// Instruction SRAM port between the fetch stage and the synchronous
// instruction memory. The fetch stage is the master: it presents an address
// and enable, and the memory answers with read data one cycle later.
interface if_stage_if;
  logic        en;     // read enable
  logic [3:0]  wen;    // byte write enables (fetch never writes)
  logic [31:0] addr;   // fetch address
  logic [31:0] wdata;  // write data (fetch never writes)
  logic [31:0] rdata;  // word for the address presented on the previous cycle

  modport master (
    output en,
    output wen,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  en,
    input  wen,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID slot.
//
// The stage owns the PC of the instruction sitting in ID (pc_reg) and drives
// the synchronous instruction SRAM with the address of the instruction that
// will occupy ID on the next cycle (nextpc). Because the SRAM answers one
// cycle later, the word on rdata always belongs to pc_reg, except while the
// stage is stalled and the SRAM is idle; then a one-entry buffer keeps the
// captured word so ID sees a stable instruction.
//
// MIPS delay slots: a taken branch resolved in ID does not redirect at once.
// Its target is parked in a pending register, the sequential instruction
// (the delay slot) is fetched first, and the following advance consumes the
// target. A second taken branch in the delay slot is ignored.
//
// Exceptions and eret redirect immediately, override a stall and flush the
// pending target, the stall buffer and the delay-slot flag.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_i,
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_is_branch_i,
  if_stage_if.master  inst_sram,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus8,
  output logic        id_is_ds,
  output logic        id_adel
);

  // ID slot state
  logic [31:0] pc_reg;        // PC of the instruction in ID
  logic        valid_reg;     // ID slot holds a real instruction
  logic        ds_reg;        // ID instruction sits in a delay slot

  // delayed branch target waiting for its delay slot to pass
  logic        pend_v_reg;
  logic [31:0] pend_tgt_reg;

  // instruction word held while the SRAM is idle during a stall
  logic        buf_v_reg;
  logic [31:0] buf_inst_reg;

  // next-state helpers
  logic        redirect;        // exception or eret this cycle
  logic        hold;            // ID slot keeps its contents
  logic        use_pend;        // this advance consumes the pending target
  logic        take_branch;     // this advance records a new pending target
  logic [31:0] pc_plus4;
  logic [31:0] nextpc;
  logic        next_misaligned; // fetch address is not word aligned
  logic        id_misaligned;   // ID PC is not word aligned

  assign redirect = exc_i | eret_i;

  // A stall only holds the slot once it is filled; an empty slot after reset
  // always refetches, and redirects always win.
  assign hold = valid_reg & stall_i & ~redirect;

  assign use_pend = valid_reg & ~stall_i & ~redirect & pend_v_reg;

  // A branch in the delay slot of another branch (pend_v_reg set) is ignored.
  assign take_branch = ~stall_i & ~redirect & ~pend_v_reg & branch_taken_i;

  assign pc_plus4 = pc_reg + 32'd4;

  // Choose the address of the instruction that will occupy ID next cycle.
  always_comb begin
    nextpc = pc_plus4;
    if (exc_i) begin
      nextpc = EXC_VECTOR;
    end else if (eret_i) begin
      nextpc = epc_i;
    end else if (!valid_reg) begin
      nextpc = pc_reg;
    end else if (stall_i) begin
      nextpc = pc_reg;
    end else if (pend_v_reg) begin
      nextpc = pend_tgt_reg;
    end
  end

  assign next_misaligned = (nextpc[1:0] != 2'b00);

  // No read while holding, and never for a misaligned address; that fetch
  // turns into a fetch-ADEL bubble in ID instead.
  assign inst_sram.en    = resetn & ~hold & ~next_misaligned;
  assign inst_sram.addr  = resetn ? nextpc : RESET_PC;
  assign inst_sram.wen   = 4'b0000;
  assign inst_sram.wdata = 32'h0000_0000;

  // Advance the ID slot to nextpc on every cycle that is not a hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg    <= RESET_PC;
      valid_reg <= 1'b0;
    end else if (!hold) begin
      pc_reg    <= nextpc;
      valid_reg <= 1'b1;
    end
  end

  // Record a taken branch's target, and drop it once the delay slot is past.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_v_reg   <= 1'b0;
      pend_tgt_reg <= 32'h0000_0000;
    end else if (redirect) begin
      pend_v_reg   <= 1'b0;
    end else if (use_pend) begin
      pend_v_reg   <= 1'b0;
    end else if (take_branch) begin
      pend_v_reg   <= 1'b1;
      pend_tgt_reg <= branch_target_i;
    end
  end

  // Capture the SRAM word on the first held cycle; release it on advance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_v_reg    <= 1'b0;
      buf_inst_reg <= 32'h0000_0000;
    end else if (!hold) begin
      buf_v_reg    <= 1'b0;
    end else if (!buf_v_reg) begin
      buf_v_reg    <= 1'b1;
      buf_inst_reg <= inst_sram.rdata;
    end
  end

  // The instruction entering ID is a delay slot if the one leaving was a branch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_reg <= 1'b0;
    end else if (redirect) begin
      ds_reg <= 1'b0;
    end else if (!hold) begin
      ds_reg <= id_is_branch_i & valid_reg;
    end
  end

  assign id_misaligned = (pc_reg[1:0] != 2'b00);

  assign id_valid    = valid_reg;
  assign id_pc       = pc_reg;
  assign id_pc_plus8 = pc_reg + 32'd8;
  assign id_is_ds    = ds_reg;
  assign id_adel     = valid_reg & id_misaligned;

  // Bubbles and misaligned fetches present a nop to the decoder.
  always_comb begin
    id_inst = 32'h0000_0000;
    if (valid_reg && !id_misaligned) begin
      id_inst = buf_v_reg ? buf_inst_reg : inst_sram.rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for the instruction-fetch stage: directed scenarios with literal
// expectations, plus a per-cycle comparison against a rule-level model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall_i = 1'b0;
  logic        exc_i = 1'b0;
  logic        eret_i = 1'b0;
  logic [31:0] epc_i = 32'h0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        id_is_branch_i = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus8;
  logic        id_is_ds;
  logic        id_adel;

  if_stage_if sram ();

  if_stage #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall_i        (stall_i),
    .exc_i          (exc_i),
    .eret_i         (eret_i),
    .epc_i          (epc_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .id_is_branch_i (id_is_branch_i),
    .inst_sram      (sram.master),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_pc_plus8    (id_pc_plus8),
    .id_is_ds       (id_is_ds),
    .id_adel        (id_adel)
  );

  always #5 clk = ~clk;

  // Memory contents: every word is its own address scrambled.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Synchronous SRAM: word for the enabled address appears next cycle and is
  // held while idle; 'garbage' corrupts the read bus to exercise buffering.
  logic [31:0] sram_q = 32'h0;
  logic        garbage = 1'b0;
  always @(posedge clk) begin
    if (sram.en) sram_q <= mem_word(sram.addr);
  end
  assign sram.rdata = garbage ? 32'hDEAD_BEEF : sram_q;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- rule-level model ----------------
  // State: which PC is in ID, whether it is real, whether a branch target is
  // waiting, and whether the ID instruction is a delay slot.
  logic [31:0] m_pc = RESET_PC;
  logic        m_valid = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt = 32'h0;
  logic        m_ds = 1'b0;

  function automatic logic [31:0] model_fetch();
    if (exc_i) return EXC_VECTOR;
    if (eret_i) return epc_i;
    if (!m_valid || stall_i) return m_pc;
    if (m_pend) return m_tgt;
    return m_pc + 32'd4;
  endfunction

  function automatic logic model_moves();
    return exc_i || eret_i || !m_valid || !stall_i;
  endfunction

  initial begin
    logic [31:0] nxt;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_pc = RESET_PC; m_valid = 1'b0; m_pend = 1'b0; m_ds = 1'b0;
      end else if (model_moves()) begin
        nxt = model_fetch();
        if (exc_i || eret_i) begin
          m_pend = 1'b0;
          m_ds = 1'b0;
        end else begin
          if (!stall_i && m_pend) m_pend = 1'b0;
          else if (!stall_i && branch_taken_i) begin
            m_pend = 1'b1;
            m_tgt = branch_target_i;
          end
          m_ds = id_is_branch_i && m_valid;
        end
        m_pc = nxt;
        m_valid = 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    logic        e_adel;
    logic [31:0] e_next;
    forever begin
      @(negedge clk);
      cyc++;
      e_adel = m_valid && (m_pc[1:0] != 2'b00);
      e_next = model_fetch();
      check1 ("en",    sram.en, resetn && model_moves() && (e_next[1:0] == 2'b00));
      check32("addr",  sram.addr, resetn ? e_next : RESET_PC);
      check32("wen",   {28'h0, sram.wen}, 32'h0);
      check32("wdata", sram.wdata, 32'h0);
      check1 ("valid", id_valid, m_valid);
      check32("pc",    id_pc, m_pc);
      check32("pc8",   id_pc_plus8, m_pc + 32'd8);
      check1 ("ds",    id_is_ds, m_ds);
      check1 ("adel",  id_adel, e_adel);
      check32("inst",  id_inst, (m_valid && !e_adel) ? mem_word(m_pc) : 32'h0);
      $display("cyc %0d rst_n=%b v=%b pc=%h inst=%h ds=%b adel=%b en=%b addr=%h",
               cyc, resetn, id_valid, id_pc, id_inst, id_is_ds, id_adel, sram.en, sram.addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_branch(input logic taken, input logic [31:0] tgt);
    branch_taken_i = taken;
    branch_target_i = tgt;
    id_is_branch_i = taken;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [23:0] stall_pat;
    stall_pat = 24'b0011_0100_0111_0010_0110_0100;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check1 ("rst en",    sram.en, 1'b0);
    check32("rst addr",  sram.addr, 32'hBFC0_0000);
    check1 ("rst valid", id_valid, 1'b0);

    // reset release: startup refetch
    tick(); resetn = 1'b1;
    @(negedge clk);
    check32("c0 addr",  sram.addr, 32'hBFC0_0000);
    check1 ("c0 en",    sram.en, 1'b1);
    check1 ("c0 valid", id_valid, 1'b0);
    tick();
    @(negedge clk);
    check1 ("c1 valid", id_valid, 1'b1);
    check32("c1 pc",    id_pc, 32'hBFC0_0000);
    check32("c1 inst",  id_inst, 32'hE59A_5A5A);
    tick();
    @(negedge clk);
    check32("c2 pc", id_pc, 32'hBFC0_0004);

    // taken branch at BFC00010 -> BFC00100
    tick(); tick(); tick();
    set_branch(1'b1, 32'hBFC0_0100);
    @(negedge clk);
    check32("br pc",   id_pc, 32'hBFC0_0010);
    check32("br pc8",  id_pc_plus8, 32'hBFC0_0018);
    tick(); set_branch(1'b0, 32'h0);
    @(negedge clk);
    check32("slot pc", id_pc, 32'hBFC0_0014);
    check1 ("slot ds", id_is_ds, 1'b1);
    tick();
    @(negedge clk);
    check32("tgt pc",  id_pc, 32'hBFC0_0100);
    check1 ("tgt ds",  id_is_ds, 1'b0);

    // three-cycle stall, read bus garbage after the first stalled cycle
    tick(); stall_i = 1'b1;
    @(negedge clk);
    check1 ("st0 en", sram.en, 1'b0);
    tick(); garbage = 1'b1;
    @(negedge clk);
    check32("st1 inst", id_inst, 32'hE59A_5B5E);
    check1 ("st1 en",   sram.en, 1'b0);
    tick();
    @(negedge clk);
    check32("st2 inst", id_inst, 32'hE59A_5B5E);
    tick(); stall_i = 1'b0;
    @(negedge clk);
    check32("rel inst", id_inst, 32'hE59A_5B5E);
    check32("rel pc",   id_pc, 32'hBFC0_0104);
    check32("rel addr", sram.addr, 32'hBFC0_0108);
    tick(); garbage = 1'b0;
    @(negedge clk);
    check32("res pc", id_pc, 32'hBFC0_0108);

    // exception during a stall with a pending target
    set_branch(1'b1, 32'hBFC0_0400);
    tick(); set_branch(1'b0, 32'h0); stall_i = 1'b1;
    tick(); exc_i = 1'b1;
    @(negedge clk);
    check1 ("exc en",   sram.en, 1'b1);
    check32("exc addr", sram.addr, 32'hBFC0_0380);
    tick(); exc_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    check32("vec pc", id_pc, 32'hBFC0_0380);
    check1 ("vec ds", id_is_ds, 1'b0);
    tick();
    @(negedge clk);
    check32("vec4 pc", id_pc, 32'hBFC0_0384);

    // eret to a misaligned EPC
    eret_i = 1'b1; epc_i = 32'hBFC0_0022;
    @(negedge clk);
    check1 ("eret en", sram.en, 1'b0);
    tick(); eret_i = 1'b0;
    @(negedge clk);
    check32("ad0 pc",   id_pc, 32'hBFC0_0022);
    check1 ("ad0 adel", id_adel, 1'b1);
    check32("ad0 inst", id_inst, 32'h0);
    tick(); set_branch(1'b1, 32'hBFC0_0200);
    @(negedge clk);
    check32("ad1 pc",   id_pc, 32'hBFC0_0026);
    check1 ("ad1 adel", id_adel, 1'b1);
    // branch in the delay slot: its target must be ignored
    tick(); set_branch(1'b1, 32'hBFC0_0300);
    @(negedge clk);
    check32("ad2 pc", id_pc, 32'hBFC0_002A);
    tick(); set_branch(1'b0, 32'h0);
    @(negedge clk);
    check32("al pc",   id_pc, 32'hBFC0_0200);
    check1 ("al adel", id_adel, 1'b0);
    tick();
    @(negedge clk);
    check32("al4 pc", id_pc, 32'hBFC0_0204);

    // PC wrap at the top of the address space
    eret_i = 1'b1; epc_i = 32'hFFFF_FFF8;
    tick(); eret_i = 1'b0;
    tick();
    @(negedge clk);
    check32("top pc",  id_pc, 32'hFFFF_FFFC);
    check32("top pc8", id_pc_plus8, 32'h0000_0004);
    tick();
    @(negedge clk);
    check32("wrap pc",   id_pc, 32'h0000_0000);
    check32("wrap inst", id_inst, 32'h5A5A_5A5A);

    // reset in mid-operation with a pending target and a full buffer
    set_branch(1'b1, 32'hBFC0_0500);
    tick(); set_branch(1'b0, 32'h0); stall_i = 1'b1;
    tick();
    tick(); resetn = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    check1 ("mr en",    sram.en, 1'b0);
    check1 ("mr valid", id_valid, 1'b0);
    check32("mr inst",  id_inst, 32'h0);
    tick(); tick(); resetn = 1'b1;
    @(negedge clk);
    check1 ("mr0 en", sram.en, 1'b1);
    tick();
    @(negedge clk);
    check32("mr1 pc", id_pc, 32'hBFC0_0000);
    tick();
    @(negedge clk);
    check32("mr2 pc", id_pc, 32'hBFC0_0004);

    // mixed stalls and a branch, checked by the model alone
    for (int i = 0; i < 24; i++) begin
      tick();
      stall_i = stall_pat[i];
      set_branch(i == 6, 32'hBFC0_0040);
    end
    tick();
    stall_i = 1'b0;
    set_branch(1'b0, 32'h0);
    tick(); tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
